lsb_mem_ctrl: RTL and testbench
===============================

LSB_MEM_CTRL -- requirements
Module: lsb_mem_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports clk_in (clock) and rst_in (reset).
REQ-002 clk_in  in  1  system clock; all state updates on posedge.
REQ-003 rst_in  in  1  synchronous active-high reset.
REQ-004 rdy_in  in  1  global ready; low = hold all state and outputs.
REQ-005 clear_flag  in  1  pipeline flush from ROB.
REQ-006 full_mem  in  1  LSB request valid, held high until mem_ready observed.
REQ-007 addr  in  32  request byte address.
REQ-008 data  in  32  store data, little-endian.
REQ-009 op  in  4  op[3]=1 store / 0 load; op[2:0]=funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-010 mem_ready  out  1  one-cycle pulse: request complete.
REQ-011 mem_val  out  32  load result, valid only while mem_ready=1 and the request was a load.
REQ-012 mem_din  in  8  RAM read byte, valid the cycle after mem_a presented.
REQ-013 mem_dout  out  8  RAM write byte.
REQ-014 mem_a  out  32  RAM byte address.
REQ-015 mem_wr  out  1  1 = write mem_dout to mem_a this cycle.
REQ-016 io_buffer_full  in  1  UART buffer full; blocks writes to 0x30000/0x30004.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, DONE; all outputs registered.
REQ-018 Byte count n SHALL be 1 for op[1:0]=00, 2 for 01, 4 for 10.
REQ-019 IDLE: on full_mem=1 at edge T, SHALL latch addr/data/op, drive mem_a=addr, go READ (op[3]=0) or WRITE (op[3]=1); for WRITE also drive mem_wr=1, mem_dout=data[7:0].
REQ-020 READ: SHALL drive mem_a=addr+k at edge T+k for k=0..n-1, mem_wr=0; SHALL capture mem_din at edge T+k+1 into mem_val byte k.
REQ-021 READ: at edge T+n SHALL assert mem_ready=1 with mem_val extended: op[2]=0 sign-extend from bit 8n-1, op[2]=1 zero-extend; word unchanged; then go DONE.
REQ-022 WRITE: byte k SHALL be driven as mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1; at edge after last byte SHALL drive mem_wr=0, mem_ready=1, go DONE.
REQ-023 WRITE: if addr[31:0] is 0x30000 or 0x30004 and io_buffer_full=1, SHALL drive mem_wr=0 and not advance k until io_buffer_full=0.
REQ-024 DONE: SHALL drive mem_ready=0 and return IDLE without sampling full_mem (LSB drops full_mem that edge); back-to-back requests thus have one dead cycle.
REQ-025 Address arithmetic SHALL be 32-bit modulo (0xFFFFFFFF+1 = 0); no alignment check.
REQ-026 clear_flag=1 in READ SHALL abort to IDLE, mem_ready=0, mem_wr=0; in IDLE/DONE SHALL force IDLE.
REQ-027 clear_flag=1 in WRITE SHALL finish remaining bytes (committed store) but suppress mem_ready, then go DONE.
REQ-028 rdy_in=0 SHALL freeze state, counters and every output (mem_wr held; RAM ignores while rdy_in=0).
REQ-029 mem_ready SHALL never be high two consecutive cycles.

Reset
REQ-030 On rst_in=1 SHALL go IDLE, k=0; mem_ready=0, mem_val=0, mem_a=0, mem_dout=0, mem_wr=0; overrides rdy_in and clear_flag.
REQ-031 Reset mid-WRITE SHALL drop mem_wr the following cycle; partial bytes already written are not undone.

Verification
REQ-032 lw addr=0x100, RAM 0x100..0x103 = 78 56 34 12 -> mem_a 0x100..0x103 on four cycles, mem_ready pulse at T+4, mem_val=0x12345678.
REQ-033 lb addr=0x200 byte 0x80 -> mem_val=0xFFFFFF80 at T+1; lbu same -> 0x00000080; lh bytes 00 80 -> 0xFFFF8000.
REQ-034 sw addr=0x400 data=0xDEADBEEF -> writes EF,BE,AD,DE to 0x400..0x403 with mem_wr=1 four cycles, mem_ready at T+4, DONE cycle, IDLE.
REQ-035 sb addr=0x30000 data=0x41, io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles, write 0x41 when released, single mem_ready.
REQ-036 lw in flight + clear_flag at T+2 -> no mem_ready, IDLE next cycle; sw in flight + clear_flag -> all 4 bytes written, no mem_ready.
REQ-037 rdy_in=0 for 2 cycles mid-lw, and rst_in mid-sw -> lw result unchanged, latency +2; rst gives mem_wr=0, mem_ready=0 next cycle.

Source files
------------

// File: rtl/lsb_mem_ctrl_if.sv
// Request/response and byte-RAM signals shared by the LSB side, the RAM and lsb_mem_ctrl.
interface lsb_mem_ctrl_if;
  // LSB request / response
  logic        full_mem;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  op;
  logic        mem_ready;
  logic [31:0] mem_val;
  // byte-wide RAM port and UART back-pressure
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  // Environment side: LSB requester plus RAM/UART
  modport master (
    output full_mem, addr, data, op, mem_din, io_buffer_full,
    input  mem_ready, mem_val, mem_dout, mem_a, mem_wr
  );

  // Controller side
  modport slave (
    input  full_mem, addr, data, op, mem_din, io_buffer_full,
    output mem_ready, mem_val, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/lsb_mem_ctrl.sv
// lsb_mem_ctrl: serialises LSB loads/stores of 1/2/4 bytes onto a byte-wide RAM port.
module lsb_mem_ctrl (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear_flag,
  lsb_mem_ctrl_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 2;
  localparam logic [AW-1:0] IO_ADDR0 = 32'h0003_0000;
  localparam logic [AW-1:0] IO_ADDR1 = 32'h0003_0004;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic          clr_seen_q;

  logic          mem_ready_q;
  logic [DW-1:0] mem_val_q;
  logic [AW-1:0] mem_a_q;
  logic [BW-1:0] mem_dout_q;
  logic          mem_wr_q;

  logic [CW-1:0] last_idx_d;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] addr_nxt_d;
  logic [BW-1:0] dout_nxt_d;
  logic [DW-1:0] raw_d;
  logic [DW-1:0] ext_d;
  logic          io_blk_new_d;
  logic          io_blk_cur_d;

  // Byte index arithmetic, UART blocking and load-result assembly/extension
  always_comb begin
    case (op_q[1:0])
      2'b00:   last_idx_d = 2'd0;
      2'b01:   last_idx_d = 2'd1;
      default: last_idx_d = 2'd3;
    endcase

    cnt_d      = cnt_q + 2'd1;
    addr_nxt_d = addr_q + AW'(cnt_d);
    dout_nxt_d = BW'(data_q >> {cnt_d, 3'b000});

    io_blk_new_d = bus.io_buffer_full && ((bus.addr == IO_ADDR0) || (bus.addr == IO_ADDR1));
    io_blk_cur_d = bus.io_buffer_full && ((addr_q == IO_ADDR0) || (addr_q == IO_ADDR1));

    raw_d = mem_val_q;
    case (cnt_q)
      2'd0:    raw_d[7:0]   = bus.mem_din;
      2'd1:    raw_d[15:8]  = bus.mem_din;
      2'd2:    raw_d[23:16] = bus.mem_din;
      default: raw_d[31:24] = bus.mem_din;
    endcase

    case (op_q[1:0])
      2'b00:   ext_d = op_q[2] ? {24'h0, raw_d[7:0]}   : {{24{raw_d[7]}},  raw_d[7:0]};
      2'b01:   ext_d = op_q[2] ? {16'h0, raw_d[15:0]}  : {{16{raw_d[15]}}, raw_d[15:0]};
      default: ext_d = raw_d;
    endcase
  end

  // Controller FSM with all outputs registered; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      clr_seen_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_val_q   <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
    end else if (rdy_in) begin
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!clear_flag && bus.full_mem) begin
            addr_q     <= bus.addr;
            data_q     <= bus.data;
            op_q       <= bus.op[2:0];
            cnt_q      <= '0;
            clr_seen_q <= 1'b0;
            mem_a_q    <= bus.addr;
            if (bus.op[3]) begin
              state_q    <= WRITE;
              mem_dout_q <= bus.data[7:0];
              mem_wr_q   <= !io_blk_new_d;
            end else begin
              state_q  <= READ;
              mem_wr_q <= 1'b0;
            end
          end
        end

        READ: begin
          mem_wr_q <= 1'b0;
          if (clear_flag) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == last_idx_d) begin
            mem_val_q   <= ext_d;
            mem_ready_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            mem_val_q <= raw_d;
            cnt_q     <= cnt_d;
            mem_a_q   <= addr_nxt_d;
          end
        end

        // A store is committed: a flush only hides its completion pulse
        WRITE: begin
          clr_seen_q <= clr_seen_q | clear_flag;
          if (mem_wr_q && (cnt_q == last_idx_d)) begin
            mem_wr_q    <= 1'b0;
            mem_ready_q <= !(clr_seen_q || clear_flag);
            cnt_q       <= '0;
            state_q     <= DONE;
          end else if (mem_wr_q) begin
            cnt_q      <= cnt_d;
            mem_a_q    <= addr_nxt_d;
            mem_dout_q <= dout_nxt_d;
            mem_wr_q   <= !io_blk_cur_d;
          end else begin
            mem_wr_q <= !io_blk_cur_d;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_val   = mem_val_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Testbench for lsb_mem_ctrl: vector table, corner sequences and randomized transactions.
module tb_lsb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_flag;

  lsb_mem_ctrl_if bus ();

  lsb_mem_ctrl dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_flag (clear_flag),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  logic rand_rdy = 1'b0;
  logic rand_io  = 1'b0;
  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  exp_ram [logic [31:0]];
  logic [31:0] aseen   [$];
  logic [3:0]  ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pre;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [31:0] a);
    return exp_ram.exists(a) ? exp_ram[a] : dflt(a);
  endfunction

  function automatic int nbytes(input logic [3:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference load: gather n bytes little-endian, then sign/zero extend arithmetically
  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    n = nbytes(op);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(exp_rd(a + 32'(k))) << (8 * k));
    if (n < 4 && !op[2] && v[8*n-1]) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v | ~mask;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < nbytes(op); k++) exp_ram[a + 32'(k)] = 8'(d >> (8 * k));
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ram_rd(a + 32'(k))) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(exp_rd(a + 32'(k))) << (8 * k));
    return v;
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      ram[a + 32'(k)]     = 8'(w >> (8 * k));
      exp_ram[a + 32'(k)] = 8'(w >> (8 * k));
    end
  endfunction

  // Byte RAM: writes on an enabled edge, read data follows the presented address
  always @(posedge clk_in) begin
    if (!rst_in && rdy_in && bus.mem_wr === 1'b1) begin
      ram[bus.mem_a] = bus.mem_dout;
      wr_cnt++;
    end
    #1 bus.mem_din = ram_rd(bus.mem_a);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // One LSB request held until mem_ready; lat counts enabled edges after the accept edge
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] val, output int lat, output logic got, output int wrs);
    int w0;
    int act;
    int cyc;
    logic r;
    w0 = wr_cnt; act = 0; cyc = 0; got = 1'b0; val = '0;
    aseen.delete();
    bus.full_mem = 1'b1; bus.addr = a; bus.data = d; bus.op = op;
    while (!got && cyc < 300) begin
      r = rdy_in;
      tick();
      cyc++;
      if (r) begin
        act++;
        aseen.push_back(bus.mem_a);
      end
      if (bus.mem_ready === 1'b1) begin
        got = 1'b1;
        val = bus.mem_val;
      end else begin
        if (rand_rdy) rdy_in = ($urandom_range(7) != 0);
        if (rand_io) bus.io_buffer_full = ($urandom_range(2) == 0);
      end
    end
    lat = act - 1;
    bus.full_mem = 1'b0; rdy_in = 1'b1; bus.io_buffer_full = 1'b0;
    tick();
    chk("ready_single", 32'(bus.mem_ready), 32'd0);
    wrs = wr_cnt - w0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val, a, d, w;
    logic [3:0]  op;
    int lat, wrs, n, w0, cyc, rdys;
    logic got, bad;

    vecs[0]  = '{4'b0010, 32'h0000_0100, 32'h0,         32'h1234_5678, 32'h1234_5678, 4, "lw_100"};
    vecs[1]  = '{4'b0000, 32'h0000_0200, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 1, "lb_neg"};
    vecs[2]  = '{4'b0100, 32'h0000_0200, 32'h0,         32'h0000_0080, 32'h0000_0080, 1, "lbu"};
    vecs[3]  = '{4'b0001, 32'h0000_0300, 32'h0,         32'h0000_8000, 32'hFFFF_8000, 2, "lh_neg"};
    vecs[4]  = '{4'b0101, 32'h0000_0300, 32'h0,         32'h0000_8000, 32'h0000_8000, 2, "lhu"};
    vecs[5]  = '{4'b0000, 32'h0000_0204, 32'h0,         32'h0000_007F, 32'h0000_007F, 1, "lb_pos"};
    vecs[6]  = '{4'b0101, 32'h0000_030A, 32'h0,         32'h0000_FFFF, 32'h0000_FFFF, 2, "lhu_ff"};
    vecs[7]  = '{4'b0010, 32'hFFFF_FFFE, 32'h0,         32'hA1B2_C3D4, 32'hA1B2_C3D4, 4, "lw_wrap"};
    vecs[8]  = '{4'b1010, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 4, "sw_400"};
    vecs[9]  = '{4'b1000, 32'h0000_0500, 32'h1234_5641, 32'hCAFE_BABE, 32'hCAFE_BA41, 1, "sb"};
    vecs[10] = '{4'b1001, 32'h0000_0600, 32'hFFFF_BEEF, 32'h1122_3344, 32'h1122_BEEF, 2, "sh"};
    vecs[11] = '{4'b1010, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0000_0000, 32'h0102_0304, 4, "sw_wrap"};

    // Reset wins over a low rdy_in
    rst_in = 1'b1; rdy_in = 1'b0; clear_flag = 1'b0;
    bus.full_mem = 1'b0; bus.addr = '0; bus.data = '0; bus.op = '0; bus.io_buffer_full = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_val",   bus.mem_val,        32'd0);
    chk("rst_a",     bus.mem_a,          32'd0);
    chk("rst_dout",  32'(bus.mem_dout),  32'd0);
    chk("rst_wr",    32'(bus.mem_wr),    32'd0);
    rst_in = 1'b0; rdy_in = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].addr, vecs[i].pre);
      n = nbytes(vecs[i].op);
      do_txn(vecs[i].op, vecs[i].addr, vecs[i].data, val, lat, got, wrs);
      chk($sformatf("%s_ready", vecs[i].nm), 32'(got), 32'd1);
      chk($sformatf("%s_lat", vecs[i].nm), 32'(lat), 32'(vecs[i].lat));
      if (!vecs[i].op[3]) begin
        chk($sformatf("%s_val", vecs[i].nm), val, vecs[i].exp);
        bad = (aseen.size() < n);
        for (int k = 0; k < n && k < aseen.size(); k++)
          if (aseen[k] !== vecs[i].addr + 32'(k)) bad = 1'b1;
        chk($sformatf("%s_addr_seq", vecs[i].nm), 32'(bad), 32'd0);
      end else begin
        model_store(vecs[i].op, vecs[i].addr, vecs[i].data);
        chk($sformatf("%s_mem", vecs[i].nm), ram_word(vecs[i].addr, 4), vecs[i].exp);
        chk($sformatf("%s_wrs", vecs[i].nm), 32'(wrs), 32'(n));
      end
    end

    // UART full stalls the store byte for three cycles
    w0 = wr_cnt;
    bus.io_buffer_full = 1'b1;
    bus.full_mem = 1'b1; bus.addr = 32'h0003_0000; bus.data = 32'h0000_0041; bus.op = 4'b1000;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("io_stall_wr", 32'(bus.mem_wr), 32'd0);
      if (k < 2) tick();
    end
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_release_wr",   32'(bus.mem_wr),   32'd1);
    chk("io_release_dout", 32'(bus.mem_dout), 32'h41);
    chk("io_release_a",    bus.mem_a,         32'h0003_0000);
    tick();
    chk("io_ready", 32'(bus.mem_ready), 32'd1);
    bus.full_mem = 1'b0;
    rdys = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.mem_ready === 1'b1) rdys++;
    end
    chk("io_ready_once", 32'(rdys), 32'd0);
    chk("io_mem", 32'(ram_rd(32'h0003_0000)), 32'h41);
    chk("io_wrs", 32'(wr_cnt - w0), 32'd1);
    model_store(4'b1000, 32'h0003_0000, 32'h41);

    // Flush during a word load: aborts with no completion
    rdys = 0;
    bus.full_mem = 1'b1; bus.addr = 32'h0000_0100; bus.op = 4'b0010;
    tick();
    if (bus.mem_ready === 1'b1) rdys++;
    tick();
    if (bus.mem_ready === 1'b1) rdys++;
    clear_flag = 1'b1;
    tick();
    if (bus.mem_ready === 1'b1) rdys++;
    clear_flag = 1'b0; bus.full_mem = 1'b0;
    chk("clr_ld_ready", 32'(rdys), 32'd0);
    chk("clr_ld_wr", 32'(bus.mem_wr), 32'd0);
    do_txn(4'b0000, 32'h0000_0200, 32'h0, val, lat, got, wrs);
    chk("clr_ld_next_lat", 32'(lat), 32'd1);
    chk("clr_ld_next_val", val, 32'hFFFF_FF80);

    // Flush during a word store: all bytes land, completion hidden
    w0 = wr_cnt; rdys = 0;
    bus.full_mem = 1'b1; bus.addr = 32'h0000_0700; bus.data = 32'h0BAD_F00D; bus.op = 4'b1010;
    tick();
    clear_flag = 1'b1; bus.full_mem = 1'b0;
    tick();
    clear_flag = 1'b0;
    if (bus.mem_ready === 1'b1) rdys++;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.mem_ready === 1'b1) rdys++;
    end
    chk("clr_st_ready", 32'(rdys), 32'd0);
    chk("clr_st_wrs", 32'(wr_cnt - w0), 32'd4);
    chk("clr_st_mem", ram_word(32'h0000_0700, 4), 32'h0BAD_F00D);
    model_store(4'b1010, 32'h0000_0700, 32'h0BAD_F00D);

    // rdy_in low for two cycles mid-load: same result, two cycles later
    bus.full_mem = 1'b1; bus.addr = 32'h0000_0100; bus.op = 4'b0010;
    tick();
    tick();
    rdy_in = 1'b0;
    tick();
    chk("frz_a1", bus.mem_a, 32'h0000_0101);
    tick();
    chk("frz_a2", bus.mem_a, 32'h0000_0101);
    chk("frz_ready", 32'(bus.mem_ready), 32'd0);
    rdy_in = 1'b1;
    cyc = 0; got = 1'b0; val = '0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (bus.mem_ready === 1'b1) begin
        got = 1'b1;
        val = bus.mem_val;
      end
    end
    bus.full_mem = 1'b0;
    chk("frz_got", 32'(got), 32'd1);
    chk("frz_total_lat", 32'(1 + 2 + cyc), 32'd6);
    chk("frz_val", val, 32'h1234_5678);
    tick();

    // Reset in the middle of a store
    bus.full_mem = 1'b1; bus.addr = 32'h0000_0800; bus.data = 32'h1122_3344; bus.op = 4'b1010;
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    chk("rst_mid_wr",    32'(bus.mem_wr),    32'd0);
    chk("rst_mid_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_mid_a",     bus.mem_a,          32'd0);
    chk("rst_mid_val",   bus.mem_val,        32'd0);
    rst_in = 1'b0; bus.full_mem = 1'b0;
    chk("rst_mid_byte0", 32'(ram_rd(32'h0000_0800)), 32'h44);
    do_txn(4'b0000, 32'h0000_0200, 32'h0, val, lat, got, wrs);
    chk("rst_mid_next_lat", 32'(lat), 32'd1);

    // Randomized transactions against the transaction-level model
    rand_rdy = 1'b1; rand_io = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(7)];
      case ($urandom_range(3))
        0:       a = $urandom;
        1:       a = 32'hFFFF_FFFC + 32'($urandom_range(3));
        2:       a = ($urandom_range(1) == 0) ? 32'h0003_0000 : 32'h0003_0004;
        default: a = 32'h0000_1000 + 32'($urandom_range(15));
      endcase
      d = $urandom;
      n = nbytes(op);
      do_txn(op, a, d, val, lat, got, wrs);
      chk($sformatf("rnd%0d_ready", i), 32'(got), 32'd1);
      if (!op[3]) begin
        chk($sformatf("rnd%0d_val op=%h a=%h", i, op, a), val, model_load(op, a));
        chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(n));
        chk($sformatf("rnd%0d_wrs", i), 32'(wrs), 32'd0);
      end else begin
        model_store(op, a, d);
        w = exp_word(a, n);
        chk($sformatf("rnd%0d_mem op=%h a=%h", i, op, a), ram_word(a, n), w);
        chk($sformatf("rnd%0d_wrs", i), 32'(wrs), 32'(n));
        if (a != 32'h0003_0000 && a != 32'h0003_0004)
          chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(n));
      end
    end
    rand_rdy = 1'b0; rand_io = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
